// File: rtl/control_unit_if.sv
// control_unit_if -- bundles the instruction/handshake inputs and decoded
// control outputs of control_unit.
//
// Parameters:
//   INST_W      instruction word width (opcode is the top 5 bits)
//   STACK_DEPTH return-stack entries tracked by the control unit
//
// Signals:
//   inst, eq, stall, run                    driven by the master (datapath/tb)
//   WrEn, pc_load, pc_inc, acc_load,
//   push, pop                               single-cycle strobes from the slave
//   e, stack_mux, add_mux, jump_mux         level controls from the slave
//   state_o, halted, fault, stack_depth     status from the slave
//
// Modports: master (drives inputs, observes controls), slave (control_unit).
interface control_unit_if #(
  parameter int INST_W      = 5,
  parameter int STACK_DEPTH = 8
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);

  logic [INST_W-1:0] inst;
  logic              eq;
  logic              stall;
  logic              run;

  logic              WrEn;
  logic              pc_load;
  logic              pc_inc;
  logic              acc_load;
  logic              push;
  logic              pop;
  logic              e;
  logic              stack_mux;
  logic              add_mux;
  logic              jump_mux;
  logic [2:0]        state_o;
  logic              halted;
  logic              fault;
  logic [SPW-1:0]    stack_depth;

  modport master (
    output inst, eq, stall, run,
    input  WrEn, pc_load, pc_inc, acc_load, push, pop,
    input  e, stack_mux, add_mux, jump_mux,
    input  state_o, halted, fault, stack_depth
  );

  modport slave (
    input  inst, eq, stall, run,
    output WrEn, pc_load, pc_inc, acc_load, push, pop,
    output e, stack_mux, add_mux, jump_mux,
    output state_o, halted, fault, stack_depth
  );
endinterface

// File: rtl/control_unit.sv
// control_unit -- three-phase (FETCH/EXEC1/EXEC2) instruction sequencer with
// HALT state and return-stack depth tracking.
//
// Parameters:
//   INST_W      instruction width (>=5); opcode = inst[INST_W-1:INST_W-5]
//   STACK_DEPTH return-stack entries tracked (>=1)
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  control_unit_if.slave: inst/eq/stall/run in; strobes, levels and
//        status (state_o, halted, fault, stack_depth) out
//
// Optional feature macro: CONTROL_UNIT_STACK_GUARD_EN
//   When defined, a JMS at full depth or a BBL at zero depth enters a FAULT
//   state that only reset can leave. When undefined, there is no FAULT state,
//   the strobes are issued normally and the depth counter saturates.
module control_unit #(
  parameter int INST_W      = 5,
  parameter int STACK_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  control_unit_if.slave  bus
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam logic [SPW-1:0] DEPTH_MAX = SPW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC1 = 3'd1,
    ST_EXEC2 = 3'd2,
`ifdef CONTROL_UNIT_STACK_GUARD_EN
    ST_FAULT = 3'd4,
`endif
    ST_HALT  = 3'd3
  } state_t;

  state_t         state_reg, state_next;
  logic [4:0]     ir_reg, ir_next;
  logic [SPW-1:0] depth_reg, depth_next;
  logic [4:0]     opcode;

  // Opcode field is the top five bits of the instruction word.
  for (genvar gi = 0; gi < 5; gi++) begin : g_opcode
    assign opcode[gi] = bus.inst[INST_W-5+gi];
  end

  // Decode works exclusively on the latched opcode so nothing downstream is
  // combinational from inst.
  logic op_sta, op_jmp, op_jeq, op_stp, op_lda, op_add, op_jms, op_bbl, op_ldr;
  always_comb begin
    op_sta = (ir_reg[4:1] == 4'b0000);
    op_jmp = (ir_reg[4:1] == 4'b0001);
    op_jeq = (ir_reg[4:2] == 3'b001);
    op_stp = (ir_reg[4:1] == 4'b0100);
    op_lda = (ir_reg      == 5'b01010);
    op_add = (ir_reg      == 5'b01011);
    op_jms = (ir_reg[4:1] == 4'b0110);
    op_bbl = (ir_reg[4:1] == 4'b0111);
    op_ldr = (ir_reg[4:1] == 4'b1110);
  end

  logic stack_err;
`ifdef CONTROL_UNIT_STACK_GUARD_EN
  assign stack_err = (op_jms && (depth_reg == DEPTH_MAX)) ||
                     (op_bbl && (depth_reg == '0));
`else
  assign stack_err = 1'b0;
`endif

  logic wr_en_s, pc_load_s, pc_inc_s, acc_load_s, push_s, pop_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_FETCH;
      ir_reg    <= '0;
      depth_reg <= '0;
    end else begin
      state_reg <= state_next;
      ir_reg    <= ir_next;
      depth_reg <= depth_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ir_next    = ir_reg;
    wr_en_s    = 1'b0;
    pc_load_s  = 1'b0;
    pc_inc_s   = 1'b0;
    acc_load_s = 1'b0;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        if (!bus.stall) begin
          pc_inc_s   = 1'b1;
          ir_next    = opcode;
          state_next = ST_EXEC1;
        end
      end
      ST_EXEC1: begin
        if (!bus.stall) begin
          if (op_stp) begin
            // STP skips EXEC2 entirely, so no pc_inc for this instruction.
            state_next = ST_HALT;
          end else
`ifdef CONTROL_UNIT_STACK_GUARD_EN
          if (stack_err) begin
            state_next = ST_FAULT;
          end else
`endif
          begin
            state_next = ST_EXEC2;
            wr_en_s    = op_sta;
            pc_load_s  = op_jmp | (op_jeq & ~bus.eq) | op_jms | op_bbl;
            push_s     = op_jms;
            pop_s      = op_bbl;
          end
        end
      end
      ST_EXEC2: begin
        if (!bus.stall) begin
          pc_inc_s   = 1'b1;
          acc_load_s = op_lda | op_ldr | op_add;
          state_next = ST_FETCH;
        end
      end
      ST_HALT: begin
        if (bus.run) state_next = ST_FETCH;
      end
`ifdef CONTROL_UNIT_STACK_GUARD_EN
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
`endif
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  // Depth counter follows the strobes and saturates at both ends.
  always_comb begin
    depth_next = depth_reg;
    if (push_s && (depth_reg < DEPTH_MAX)) begin
      depth_next = depth_reg + 1'b1;
    end else if (pop_s && (depth_reg != '0)) begin
      depth_next = depth_reg - 1'b1;
    end
  end

  assign bus.WrEn        = wr_en_s;
  assign bus.pc_load     = pc_load_s;
  assign bus.jump_mux    = pc_load_s;
  assign bus.pc_inc      = pc_inc_s;
  assign bus.acc_load    = acc_load_s;
  assign bus.push        = push_s;
  assign bus.pop         = pop_s;
  assign bus.e           = op_lda | op_ldr | op_add;
  assign bus.stack_mux   = op_bbl;
  assign bus.add_mux     = op_add;
  assign bus.state_o     = {state_reg == ST_EXEC2,
                            state_reg == ST_EXEC1,
                            state_reg == ST_FETCH};
  assign bus.halted      = (state_reg == ST_HALT);
  assign bus.stack_depth = depth_reg;
`ifdef CONTROL_UNIT_STACK_GUARD_EN
  assign bus.fault       = (state_reg == ST_FAULT);
`else
  assign bus.fault       = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit -- directed, table-driven bench for control_unit
// (INST_W=5, STACK_DEPTH=3).
module tb_control_unit;
  localparam int INST_W      = 5;
  localparam int STACK_DEPTH = 3;

  logic clk;
  logic rst;

  control_unit_if #(.INST_W(INST_W), .STACK_DEPTH(STACK_DEPTH)) bus ();

  control_unit #(.INST_W(INST_W), .STACK_DEPTH(STACK_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // One cycle of stimulus: state, strobes {WrEn,pc_load,pc_inc,acc_load,
  // push,pop} and levels {e,stack_mux,add_mux,jump_mux} expected in it.
  typedef struct {
    logic [4:0] inst;
    logic       eq;
    logic       stall;
    logic [2:0] st;
    logic [5:0] strb;
    logic [3:0] lvl;
  } vec_t;

  vec_t vq[$];

  function automatic logic [16:0] obs();
    return {bus.state_o, bus.WrEn, bus.pc_load, bus.pc_inc, bus.acc_load,
            bus.push, bus.pop, bus.e, bus.stack_mux, bus.add_mux,
            bus.jump_mux, bus.halted, bus.fault, bus.stack_depth};
  endfunction

  task automatic chk(input string name, input logic [16:0] act,
                     input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%b exp=%b", name, act, exp);
    end else begin
      $display("ok   %s %b", name, act);
    end
  endtask

  task automatic cyc(input logic [4:0] i, input logic e_q, input logic s,
                     input logic r);
    @(negedge clk);
    bus.inst  = i;
    bus.eq    = e_q;
    bus.stall = s;
    bus.run   = r;
    #1;
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst       = 1'b1;
    bus.inst  = 5'b0;
    bus.eq    = 1'b0;
    bus.stall = 1'b0;
    bus.run   = 1'b0;
    #1;
    // FETCH with ir=STA: only pc_inc, depth and flags cleared.
    chk(name, obs(), {3'b001, 6'b001000, 4'b0000, 1'b0, 1'b0, 2'b00});
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Runs one stack instruction without a fault.
  task automatic stack_op(input string name, input logic [4:0] op,
                          input logic exp_push, input logic exp_pop,
                          input logic [1:0] exp_depth);
    cyc(op, 1'b0, 1'b0, 1'b0);
    cyc(op, 1'b0, 1'b0, 1'b0);
    chk({name, " exec1"}, {bus.push, bus.pop, bus.pc_load, bus.jump_mux},
        {exp_push, exp_pop, 1'b1, 1'b1});
    cyc(op, 1'b0, 1'b0, 1'b0);
    chk({name, " exec2"}, {bus.push, bus.pop, bus.stack_depth},
        {2'b00, exp_depth});
  endtask

`ifdef CONTROL_UNIT_STACK_GUARD_EN
  task automatic stack_fault(input string name, input logic [4:0] op);
    cyc(op, 1'b0, 1'b0, 1'b0);
    cyc(op, 1'b0, 1'b0, 1'b0);
    chk({name, " exec1"}, {bus.push, bus.pop, bus.pc_load, bus.jump_mux},
        4'b0000);
    cyc(op, 1'b0, 1'b0, 1'b0);
    chk({name, " fault"}, {bus.state_o, bus.fault, bus.halted, bus.pc_inc},
        {3'b000, 1'b1, 1'b0, 1'b0});
    cyc(op, 1'b0, 1'b0, 1'b1);
    cyc(op, 1'b0, 1'b0, 1'b0);
    chk({name, " fault hold"}, {bus.state_o, bus.fault, bus.pc_inc},
        {3'b000, 1'b1, 1'b0});
  endtask
`endif

  task automatic add(input logic [4:0] i, input logic e_q, input logic s,
                     input logic [2:0] st, input logic [5:0] strb,
                     input logic [3:0] lvl);
    vec_t v;
    v.inst = i; v.eq = e_q; v.stall = s; v.st = st; v.strb = strb; v.lvl = lvl;
    vq.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bus.inst  = '0;
    bus.eq    = 1'b0;
    bus.stall = 1'b0;
    bus.run   = 1'b0;

    // LDA
    add(5'b01010, 0, 0, 3'b001, 6'b001000, 4'b0000);
    add(5'b01010, 0, 0, 3'b010, 6'b000000, 4'b1000);
    add(5'b01010, 0, 0, 3'b100, 6'b001100, 4'b1000);
    // JEQ, eq=1: no jump
    add(5'b00100, 1, 0, 3'b001, 6'b001000, 4'b1000);
    add(5'b00100, 1, 0, 3'b010, 6'b000000, 4'b0000);
    add(5'b00100, 1, 0, 3'b100, 6'b001000, 4'b0000);
    // JEQ, eq=0: jump
    add(5'b00111, 0, 0, 3'b001, 6'b001000, 4'b0000);
    add(5'b00111, 0, 0, 3'b010, 6'b010000, 4'b0001);
    add(5'b00111, 0, 0, 3'b100, 6'b001000, 4'b0000);
    // STA with three stalled EXEC1 cycles
    add(5'b00000, 0, 0, 3'b001, 6'b001000, 4'b0000);
    add(5'b00000, 0, 1, 3'b010, 6'b000000, 4'b0000);
    add(5'b00000, 0, 1, 3'b010, 6'b000000, 4'b0000);
    add(5'b00000, 0, 1, 3'b010, 6'b000000, 4'b0000);
    add(5'b00000, 0, 0, 3'b010, 6'b100000, 4'b0000);
    add(5'b00000, 0, 0, 3'b100, 6'b001000, 4'b0000);
    // stalled FETCH must not latch LDA; ADD is latched on release
    add(5'b01010, 0, 1, 3'b001, 6'b000000, 4'b0000);
    add(5'b01011, 0, 0, 3'b001, 6'b001000, 4'b0000);
    add(5'b00000, 0, 0, 3'b010, 6'b000000, 4'b1010);
    add(5'b00000, 0, 0, 3'b100, 6'b001100, 4'b1010);
    // LDR
    add(5'b11101, 0, 0, 3'b001, 6'b001000, 4'b1010);
    add(5'b11101, 0, 0, 3'b010, 6'b000000, 4'b1000);
    add(5'b11101, 0, 0, 3'b100, 6'b001100, 4'b1000);
    // NOP
    add(5'b10000, 0, 0, 3'b001, 6'b001000, 4'b1000);
    add(5'b10000, 0, 0, 3'b010, 6'b000000, 4'b0000);
    add(5'b10000, 0, 0, 3'b100, 6'b001000, 4'b0000);
    // JMP
    add(5'b00010, 0, 0, 3'b001, 6'b001000, 4'b0000);
    add(5'b00010, 0, 0, 3'b010, 6'b010000, 4'b0001);
    add(5'b00010, 0, 0, 3'b100, 6'b001000, 4'b0000);

    do_reset("reset");
    foreach (vq[k]) begin
      cyc(vq[k].inst, vq[k].eq, vq[k].stall, 1'b0);
      chk($sformatf("vec%0d", k), obs(),
          {vq[k].st, vq[k].strb, vq[k].lvl, 1'b0, 1'b0, 2'b00});
    end

    // STP: halt, ten quiet cycles, run resumes in FETCH.
    do_reset("reset stp");
    cyc(5'b01000, 0, 0, 0);
    cyc(5'b01000, 0, 0, 0);
    chk("stp exec1", {bus.state_o, bus.WrEn, bus.pc_load, bus.pc_inc,
                      bus.acc_load, bus.push, bus.pop},
        {3'b010, 6'b000000});
    for (int n = 0; n < 10; n++) begin
      cyc(5'b00000, 0, 0, 0);
      chk($sformatf("halt%0d", n), {bus.state_o, bus.WrEn, bus.pc_load,
          bus.pc_inc, bus.acc_load, bus.push, bus.pop, bus.halted},
          {3'b000, 6'b000000, 1'b1});
    end
    cyc(5'b00000, 0, 0, 1);
    chk("halt run", {bus.state_o, bus.halted}, {3'b000, 1'b1});
    cyc(5'b00000, 0, 0, 0);
    chk("halt resume", {bus.state_o, bus.pc_inc, bus.halted},
        {3'b001, 1'b1, 1'b0});

    // Return stack: underflow, three calls, return, overflow.
    do_reset("reset stack");
`ifdef CONTROL_UNIT_STACK_GUARD_EN
    stack_fault("bbl underflow", 5'b01110);
    do_reset("reset after fault");
`else
    stack_op("bbl underflow", 5'b01110, 1'b0, 1'b1, 2'd0);
`endif
    stack_op("jms1", 5'b01100, 1'b1, 1'b0, 2'd1);
    stack_op("jms2", 5'b01101, 1'b1, 1'b0, 2'd2);
    stack_op("jms3", 5'b01100, 1'b1, 1'b0, 2'd3);
    stack_op("bbl1", 5'b01111, 1'b0, 1'b1, 2'd2);
    stack_op("jms4", 5'b01100, 1'b1, 1'b0, 2'd3);
`ifdef CONTROL_UNIT_STACK_GUARD_EN
    stack_fault("jms overflow", 5'b01100);
`else
    stack_op("jms overflow", 5'b01100, 1'b1, 1'b0, 2'd3);
`endif

    // Reset in the middle of a JMP aborts it; reset check also sees depth 0.
    do_reset("reset mid");
    cyc(5'b00010, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("jmp exec1", {bus.state_o, bus.pc_load}, {3'b010, 1'b1});
    rst = 1'b1;
    #1;
    chk("abort", obs(), {3'b001, 6'b001000, 4'b0000, 1'b0, 1'b0, 2'b00});
    @(posedge clk);
    #2 rst = 1'b0;
    cyc(5'b00000, 0, 0, 0);
    chk("after abort", obs(), {3'b001, 6'b001000, 4'b0000, 1'b0, 1'b0, 2'b00});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter INST_W, default 5, instruction width (>=5); opcode is inst[INST_W-1:INST_W-5], lower bits ignored.
REQ-002 Parameter STACK_DEPTH, default 8, return-stack entries tracked (>=1); SPW = clog2(STACK_DEPTH+1).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 inst  input  INST_W  instruction word, valid in FETCH.
REQ-006 eq  input  1  accumulator-equal flag, sampled in EXEC1.
REQ-007 stall  input  1  hold current state, suppress strobes.
REQ-008 run  input  1  leave HALT.
REQ-009 Outputs, 1 bit each: WrEn, pc_load, pc_inc, acc_load, push, pop (strobes); e, stack_mux, add_mux, jump_mux (levels).
REQ-010 state_o  output  3  one-hot {exec2,exec1,fetch}, 000 in HALT/FAULT.
REQ-011 halted  output  1  state is HALT.
REQ-012 fault  output  1  state is FAULT (always 0 without guard macro).
REQ-013 stack_depth  output  SPW  tracked call depth.

Function
REQ-014 States FETCH, EXEC1, EXEC2, HALT, FAULT; stall=0: FETCH->EXEC1->EXEC2->FETCH.
REQ-015 Opcode register ir SHALL load opcode on FETCH->EXEC1 edge only; all decode uses ir.
REQ-016 Encodings: STA 0000x, JMP 0001x, JEQ 001xx, STP 0100x, LDA 01010, ADD 01011, JMS 0110x, BBL 0111x, LDR 1110x; others NOP.
REQ-017 pc_inc = FETCH | EXEC2.
REQ-018 WrEn = EXEC1 & STA.
REQ-019 pc_load = jump_mux = EXEC1 & (JMP | JEQ&~eq | JMS | BBL).
REQ-020 push = EXEC1 & JMS; pop = EXEC1 & BBL; acc_load = EXEC2 & (LDA|LDR|ADD).
REQ-021 e = LDA|LDR|ADD; stack_mux = BBL; add_mux = ADD; from ir, in any state.
REQ-022 STP in EXEC1 -> HALT next edge; no pc_load, no EXEC2, no pc_inc.
REQ-023 HALT: all strobes 0; run=1 -> FETCH next edge; run ignored in other states.
REQ-024 stall=1 in FETCH/EXEC1/EXEC2: state and ir hold, all strobes 0, levels unchanged; release resumes same state.
REQ-025 stack_depth +1 on push, -1 on pop (one edge after strobe); saturates at STACK_DEPTH and 0.
REQ-026 All strobes are single-cycle per state visit; no output combinational from inst.

Reset
REQ-027 rst=1 asynchronously: state FETCH, ir 0, stack_depth 0, fault 0, halted 0.
REQ-028 Strobes from decode of ir=0 (STA) only via state: in reset, FETCH -> only pc_inc=1.
REQ-029 Reset mid-instruction aborts it; no pending strobe issued after release.

Configuration
REQ-030 Macro CONTROL_UNIT_STACK_GUARD_EN.
REQ-031 Defined: JMS in EXEC1 with stack_depth==STACK_DEPTH, or BBL with stack_depth==0 -> FAULT; that cycle push/pop/pc_load/jump_mux 0.
REQ-032 Defined: FAULT holds, all strobes 0, fault=1, exit by rst only; run ignored.
REQ-033 Undefined: no FAULT state; overflow/underflow strobes issued, counter saturates per REQ-025; fault tied 0.

Verification
REQ-034 Reset, inst=01010 (LDA) -> cycle0 pc_inc=1, cycle1 none, cycle2 acc_load=1,pc_inc=1, e=1.
REQ-035 JEQ 00100, eq=1 -> EXEC1 pc_load=0; eq=0 -> pc_load=1, jump_mux=1.
REQ-036 JMS x3 then BBL x1 -> stack_depth 1,2,3,2; push/pop one cycle each.
REQ-037 STP 01000 -> halted=1, no strobes 10 cycles; run=1 -> FETCH, pc_inc=1.
REQ-038 stall=1 three cycles in EXEC1 of STA -> WrEn=0 during stall, WrEn=1 once after release.
REQ-039 Guard on, STACK_DEPTH=2: third JMS -> fault=1, push=0; guard off -> push=1, stack_depth stays 2.
